// File: rtl/pmod_spi_pkg.sv
// Shared constants for the PMOD SPI LCD target: byte width, FIFO entry packing,
// receiver state encodings and synchroniser pin ordering.
package pmod_spi_pkg;

   localparam int SPI_BYTE_W = 8;

   typedef struct packed {
      logic                  dc;
      logic [SPI_BYTE_W-1:0] data;
   } rx_entry_t;

   localparam int RX_ENTRY_W = $bits(rx_entry_t);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] SHIFT = 1'b1;

   // Bit positions of the pins inside the synchroniser vector
   localparam int PIN_SCLK = 0;
   localparam int PIN_MOSI = 1;
   localparam int PIN_CSL  = 2;
   localparam int PIN_DC   = 3;
   localparam int PIN_RSTL = 4;
   localparam int PIN_W    = 5;
   localparam logic [PIN_W-1:0] PIN_IDLE = 5'b10100;

   function automatic rx_entry_t pack_entry(input logic dc, input logic [SPI_BYTE_W-1:0] data);
      rx_entry_t e;
      e.dc   = dc;
      e.data = data;
      return e;
   endfunction

endpackage

// File: rtl/pmod_spi_tgt_fifo.sv
// Synchronous first-word-fall-through FIFO; a push into a full FIFO only succeeds
// when a pop happens in the same cycle, otherwise o_drop flags the lost word.
module pmod_spi_tgt_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     srst,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_wdata,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_rdata,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_level,
   output logic                     o_drop
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_level;
   logic             w_pop;
   logic             w_push;

   assign o_empty = (r_level == '0);
   assign o_full  = (r_level == (AW+1)'(DEPTH));
   assign o_level = r_level;
   assign w_pop   = i_pop & ~o_empty;
   assign w_push  = i_push & (~o_full | w_pop);
   assign o_drop  = i_push & o_full & ~w_pop;

   // Head is shown as zero while empty so the stream output has a defined idle value
   assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/pmod_spi_lcd_target.sv
// LCD-side SPI target: oversamples the PMOD pins, deserialises mode-0 MSB-first bytes
// tagged with D1C0 into a FWFT FIFO. Define PMOD_SPI_TGT_MISO_EN to build the MISO echo.
module pmod_spi_lcd_target
   import pmod_spi_pkg::*;
#(
   parameter int FIFO_DEPTH  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic                          PMOD_SCLK,
   input  logic                          PMOD_MOSI,
   input  logic                          PMOD_CSL,
   input  logic                          PMOD_D1C0,
   input  logic                          PMOD_RSTL,
   output logic                          PMOD_MISO,
   output logic                          PMOD_MISO_T,
   output logic [SPI_BYTE_W-1:0]         RX_DATA,
   output logic                          RX_DC,
   output logic                          RX_VALID,
   input  logic                          RX_READY,
   output logic [$clog2(FIFO_DEPTH):0]   RX_LEVEL,
   output logic                          OVERFLOW,
   output logic                          PARTIAL,
   input  logic                          STAT_CLR
);

   logic [PIN_W-1:0] r_sync [SYNC_STAGES];
   logic             r_sclk_d;
   logic [0:0]       r_state;
   logic [2:0]       r_bit_cnt;
   logic [6:0]       r_shift;
   logic             r_push;
   rx_entry_t        r_push_entry;
   logic             r_overflow;
   logic             r_partial;

   logic w_sclk_s, w_mosi_s, w_csl_s, w_dc_s, w_rstl_s;
   logic w_tgt_rst, w_sclk_rise, w_csl_rise, w_csl_fall;
   logic w_shift_en, w_byte_done, w_partial_set;
   logic w_drop, w_empty, w_full;
   logic [RX_ENTRY_W-1:0] w_head;

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= PIN_IDLE;
      end else begin
         r_sync[0] <= {PMOD_RSTL, PMOD_D1C0, PMOD_CSL, PMOD_MOSI, PMOD_SCLK};
         for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      end
   end

   assign w_sclk_s = r_sync[SYNC_STAGES-1][PIN_SCLK];
   assign w_mosi_s = r_sync[SYNC_STAGES-1][PIN_MOSI];
   assign w_csl_s  = r_sync[SYNC_STAGES-1][PIN_CSL];
   assign w_dc_s   = r_sync[SYNC_STAGES-1][PIN_DC];
   assign w_rstl_s = r_sync[SYNC_STAGES-1][PIN_RSTL];

   assign w_tgt_rst     = RST | ~w_rstl_s;
   assign w_sclk_rise   = w_sclk_s & ~r_sclk_d;
   assign w_csl_fall    = (r_state == IDLE) & ~w_csl_s;
   assign w_csl_rise    = (r_state == SHIFT) & w_csl_s;
   // An SCLK rise coinciding with the CSL rise is dropped because w_csl_s is already high
   assign w_shift_en    = (r_state == SHIFT) & ~w_csl_s & w_sclk_rise;
   assign w_byte_done   = w_shift_en & (r_bit_cnt == 3'd7);
   assign w_partial_set = w_csl_rise & (r_bit_cnt != 3'd0);

   // Edge history keeps tracking during LCD reset so no false edge appears on release
   always_ff @(posedge CLK) begin
      if (RST) r_sclk_d <= 1'b0;
      else     r_sclk_d <= w_sclk_s;
   end

   always_ff @(posedge CLK) begin
      if (w_tgt_rst) begin
         r_state      <= IDLE;
         r_bit_cnt    <= 3'd0;
         r_shift      <= 7'd0;
         r_push       <= 1'b0;
         r_push_entry <= '0;
      end else begin
         r_push <= w_byte_done;
         if (w_byte_done) begin
            r_push_entry <= pack_entry(w_dc_s, {r_shift, w_mosi_s});
         end
         if (w_csl_fall)      r_state <= SHIFT;
         else if (w_csl_rise) r_state <= IDLE;
         if (w_csl_rise) begin
            r_bit_cnt <= 3'd0;
         end else if (w_shift_en) begin
            r_shift   <= {r_shift[5:0], w_mosi_s};
            r_bit_cnt <= r_bit_cnt + 3'd1;
         end
      end
   end

   // Set events take priority over STAT_CLR
   always_ff @(posedge CLK) begin
      if (w_tgt_rst) begin
         r_overflow <= 1'b0;
         r_partial  <= 1'b0;
      end else begin
         if (w_drop)             r_overflow <= 1'b1;
         else if (STAT_CLR)      r_overflow <= 1'b0;
         if (w_partial_set)      r_partial  <= 1'b1;
         else if (STAT_CLR)      r_partial  <= 1'b0;
      end
   end

   pmod_spi_tgt_fifo #(
      .WIDTH (RX_ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (CLK),
      .srst    (w_tgt_rst),
      .i_push  (r_push),
      .i_wdata (r_push_entry),
      .i_pop   (RX_READY),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (RX_LEVEL),
      .o_drop  (w_drop)
   );

   assign RX_DC    = w_head[RX_ENTRY_W-1];
   assign RX_DATA  = w_head[SPI_BYTE_W-1:0];
   assign RX_VALID = ~w_empty;
   assign OVERFLOW = r_overflow;
   assign PARTIAL  = r_partial;

`ifdef PMOD_SPI_TGT_MISO_EN
   logic [SPI_BYTE_W-1:0] r_echo;
   logic [SPI_BYTE_W-1:0] r_miso_sh;
   logic                  w_sclk_fall;

   assign w_sclk_fall = ~w_sclk_s & r_sclk_d;

   // The fall after a byte boundary (bit_cnt back at 0) reloads the echo for the next byte
   always_ff @(posedge CLK) begin
      if (w_tgt_rst) begin
         r_echo    <= '0;
         r_miso_sh <= '0;
      end else begin
         if (w_byte_done) begin
            r_echo <= {r_shift, w_mosi_s};
         end
         if (w_csl_fall) begin
            r_miso_sh <= r_echo;
         end else if ((r_state == SHIFT) && !w_csl_s && w_sclk_fall) begin
            r_miso_sh <= (r_bit_cnt == 3'd0) ? r_echo : {r_miso_sh[6:0], 1'b0};
         end
      end
   end

   assign PMOD_MISO   = r_miso_sh[SPI_BYTE_W-1];
   assign PMOD_MISO_T = w_csl_s;
`else
   assign PMOD_MISO   = 1'b0;
   assign PMOD_MISO_T = 1'b1;
`endif

endmodule
